// File: rtl/turn_sequencer_pkg.sv
// turn_sequencer_pkg: shared types and constants for the turn sequencer and
// the per-player position counters it drives.
//   - state_t        : turn FSM states
//   - MAX_PLAYERS    : number of move-pulse outputs
//   - BOARD_TILES    : board length seen by the position counters
//   - clamp_players  : legal player count from the raw N input
//   - start_tile     : starting tile for a player, given the player count
package turn_sequencer_pkg;

  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned PLAYER_W    = $clog2(MAX_PLAYERS);
  localparam int unsigned NLAT_W      = $clog2(MAX_PLAYERS + 1);
  localparam int unsigned NIN_W       = 4;
  localparam int unsigned STEPS_W     = 3;

  localparam int unsigned BOARD_TILES = 24;
  localparam int unsigned TILE_W      = $clog2(BOARD_TILES);

  // Players start evenly spread around the board.
  localparam int unsigned START_SPACING_N2 = BOARD_TILES / 2;
  localparam int unsigned START_SPACING_N3 = BOARD_TILES / 3;
  localparam int unsigned START_SPACING_N4 = BOARD_TILES / 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GUESS,
    STEP,
    GAP,
    NEXT,
    HALT
  } state_t;

  // Out-of-range player counts fall back to a two-player game.
  function automatic logic [NLAT_W-1:0] clamp_players(input logic [NIN_W-1:0] n);
    if ((n >= NIN_W'(2)) && (n <= NIN_W'(MAX_PLAYERS)))
      return NLAT_W'(n);
    else
      return NLAT_W'(2);
  endfunction

  // Starting tile of player p in an n-player game.
  function automatic logic [TILE_W-1:0] start_tile(input logic [NLAT_W-1:0] n,
                                                   input logic [PLAYER_W-1:0] p);
    logic [TILE_W-1:0] spacing;
    case (n)
      NLAT_W'(3): spacing = TILE_W'(START_SPACING_N3);
      NLAT_W'(4): spacing = TILE_W'(START_SPACING_N4);
      default:    spacing = TILE_W'(START_SPACING_N2);
    endcase
    return TILE_W'(TILE_W'(p) * spacing);
  endfunction

endpackage

// File: rtl/turn_sequencer_step_burst.sv
// step_burst: remaining-step counter and inter-step gap timer for one burst.
//   clk, rst : clock, synchronous active-low reset
//   load     : latch a new burst length from count (0 counts as 1)
//   count    : requested number of steps
//   go       : a step is being issued this cycle
//   pulse    : gap has elapsed; the next step may be issued next cycle
//   done     : the step being issued now is the last one of the burst
import turn_sequencer_pkg::*;

module step_burst #(
  parameter int unsigned STEP_GAP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [STEPS_W-1:0] count,
  input  logic               go,
  output logic               pulse,
  output logic               done
);

  localparam int unsigned GAP_W = (STEP_GAP < 1) ? 1 : $clog2(STEP_GAP + 1);

  logic [STEPS_W-1:0] rem;
  logic [GAP_W-1:0]   gap;

  // Remaining steps and gap countdown; a step reloads the gap timer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem <= '0;
      gap <= '0;
    end else if (load) begin
      rem <= (count == '0) ? STEPS_W'(1) : count;
      gap <= '0;
    end else if (go) begin
      rem <= rem - STEPS_W'(1);
      gap <= GAP_W'(STEP_GAP);
    end else if (gap != '0) begin
      gap <= gap - GAP_W'(1);
    end
  end

  // Gap value 1 marks the final idle cycle, so the gap lasts STEP_GAP cycles.
  assign pulse = (gap == GAP_W'(1));
  assign done  = (rem == STEPS_W'(1));

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: tracks whose turn it is and turns a matched card guess into
// a burst of one-cycle move pulses for the current player.
//   clk, rst    : clock, synchronous active-low reset
//   N           : player count, sampled in IDLE on start (2..MAX_PLAYERS, else 2)
//   start       : begin a game from IDLE
//   guess_valid : guess result strobe, honoured only while turn_active
//   guess_match : 1 = matched (move), 0 = miss (pass turn)
//   steps       : steps to move on a match (0 moves 1)
//   game_over   : freeze everything until reset
//   p_da        : one-hot move pulses, bit i drives player i+1
//   cur_player  : 0-based index of the player on turn
//   turn_active : waiting for a guess
//   busy        : stepping or passing the turn
// Optional macro TURN_TIMEOUT_EN: a guess not given within TIMEOUT_CYC cycles
// passes the turn as if it were a miss.
import turn_sequencer_pkg::*;

module turn_sequencer #(
  parameter int unsigned STEP_GAP = 2
`ifdef TURN_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NIN_W-1:0]       N,
  input  logic                   start,
  input  logic                   guess_valid,
  input  logic                   guess_match,
  input  logic [STEPS_W-1:0]     steps,
  input  logic                   game_over,
  output logic [MAX_PLAYERS-1:0] p_da,
  output logic [PLAYER_W-1:0]    cur_player,
  output logic                   turn_active,
  output logic                   busy
);

  state_t              state;
  logic [NLAT_W-1:0]   n_lat;
  logic                burst_load;
  logic                burst_go;
  logic                gap_over;
  logic                last_step;
  logic                timed_out;

  // Burst engine control: load on a matched guess, step once per STEP cycle.
  assign burst_load = (state == WAIT_GUESS) && !game_over && guess_valid && guess_match;
  assign burst_go   = (state == STEP) && !game_over;

  step_burst #(
    .STEP_GAP (STEP_GAP)
  ) u_step_burst (
    .clk   (clk),
    .rst   (rst),
    .load  (burst_load),
    .count (steps),
    .go    (burst_go),
    .pulse (gap_over),
    .done  (last_step)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] timer;

  // Held at zero outside WAIT_GUESS, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst || (state != WAIT_GUESS))
      timer <= '0;
    else
      timer <= timer + TMR_W'(1);
  end

  assign timed_out = (timer == TMR_W'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Turn FSM with registered outputs; game_over pre-empts every non-IDLE state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      n_lat       <= '0;
      p_da        <= '0;
      cur_player  <= '0;
      turn_active <= 1'b0;
      busy        <= 1'b0;
    end else begin
      p_da <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            n_lat       <= clamp_players(N);
            cur_player  <= '0;
            state       <= WAIT_GUESS;
            turn_active <= 1'b1;
            busy        <= 1'b0;
          end
        end

        WAIT_GUESS: begin
          if (game_over) begin
            state       <= HALT;
            turn_active <= 1'b0;
            busy        <= 1'b0;
          end else if (guess_valid) begin
            state       <= guess_match ? STEP : NEXT;
            turn_active <= 1'b0;
            busy        <= 1'b1;
          end else if (timed_out) begin
            state       <= NEXT;
            turn_active <= 1'b0;
            busy        <= 1'b1;
          end
        end

        STEP: begin
          if (game_over) begin
            state       <= HALT;
            turn_active <= 1'b0;
            busy        <= 1'b0;
          end else begin
            p_da <= MAX_PLAYERS'(1) << cur_player;
            if (last_step) begin
              // A match keeps the turn with the same player.
              state       <= WAIT_GUESS;
              turn_active <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (game_over) begin
            state       <= HALT;
            turn_active <= 1'b0;
            busy        <= 1'b0;
          end else if (gap_over) begin
            state <= STEP;
          end
        end

        NEXT: begin
          if (game_over) begin
            state       <= HALT;
            turn_active <= 1'b0;
            busy        <= 1'b0;
          end else begin
            if ((NLAT_W'(cur_player) + NLAT_W'(1)) == n_lat)
              cur_player <= '0;
            else
              cur_player <= cur_player + PLAYER_W'(1);
            state       <= WAIT_GUESS;
            turn_active <= 1'b1;
            busy        <= 1'b0;
          end
        end

        HALT: begin
          turn_active <= 1'b0;
          busy        <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          turn_active <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed test of turn_sequencer with STEP_GAP=2.
// Honours TURN_TIMEOUT_EN (builds the DUT with TIMEOUT_CYC=10 when defined).
module tb_turn_sequencer;
  import turn_sequencer_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NIN_W-1:0]       N;
  logic                   start;
  logic                   guess_valid;
  logic                   guess_match;
  logic [STEPS_W-1:0]     steps;
  logic                   game_over;
  logic [MAX_PLAYERS-1:0] p_da;
  logic [PLAYER_W-1:0]    cur_player;
  logic                   turn_active;
  logic                   busy;

  int errs   = 0;
  int checks = 0;
  int pulses;

`ifdef TURN_TIMEOUT_EN
  turn_sequencer #(.STEP_GAP(2), .TIMEOUT_CYC(10)) dut (
`else
  turn_sequencer #(.STEP_GAP(2)) dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .N           (N),
    .start       (start),
    .guess_valid (guess_valid),
    .guess_match (guess_match),
    .steps       (steps),
    .game_over   (game_over),
    .p_da        (p_da),
    .cur_player  (cur_player),
    .turn_active (turn_active),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic begin_game(input logic [NIN_W-1:0] n);
    N     = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic miss(input string tag, input logic [PLAYER_W-1:0] exp_next);
    guess_valid = 1'b1;
    guess_match = 1'b0;
    tick();
    guess_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " p_da"}, 32'(p_da), 32'd0);
    tick();
    check({tag, " cur"}, 32'(cur_player), 32'(exp_next));
    check({tag, " active"}, 32'(turn_active), 32'd1);
  endtask

  task automatic match(input logic [STEPS_W-1:0] s);
    guess_valid = 1'b1;
    guess_match = 1'b1;
    steps       = s;
    tick();
    guess_valid = 1'b0;
    guess_match = 1'b0;
  endtask

  initial begin
    N = '0; start = 0; guess_valid = 0; guess_match = 0; steps = '0; game_over = 0;
    rst = 1'b0;
    tick();
    tick();
    check("reset p_da", 32'(p_da), 32'd0);
    check("reset cur", 32'(cur_player), 32'd0);
    check("reset active", 32'(turn_active), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Three players, three misses: 0 -> 1 -> 2 -> 0.
    begin_game(4'd3);
    check("start active", 32'(turn_active), 32'd1);
    check("start cur", 32'(cur_player), 32'd0);
    check("start busy", 32'(busy), 32'd0);
    miss("miss0", 2'd1);
    miss("miss1", 2'd2);
    miss("miss2", 2'd0);

    // Player 1 matches with steps=3: pulses at +1, +4, +7.
    miss("to_p1", 2'd1);
    match(3'd3);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("burst3 k%0d", k), 32'(p_da),
            ((k == 1) || (k == 4) || (k == 7)) ? 32'h2 : 32'h0);
      if (k == 2) check("burst3 busy", 32'(busy), 32'd1);
    end
    check("burst3 active", 32'(turn_active), 32'd1);
    check("burst3 cur", 32'(cur_player), 32'd1);
    check("burst3 busy end", 32'(busy), 32'd0);

    // steps=0 counts as a single step.
    match(3'd0);
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (p_da == 4'b0010) pulses++;
      else if (p_da != 4'b0000) pulses += 100;
    end
    check("steps0 pulses", 32'(pulses), 32'd1);
    check("steps0 active", 32'(turn_active), 32'd1);

    // Out-of-range N=7 plays as two players; later N changes are ignored.
    do_reset();
    begin_game(4'd7);
    N = 4'd4;
    check("n7 cur", 32'(cur_player), 32'd0);
    miss("n7 miss0", 2'd1);
    miss("n7 miss1", 2'd0);

    // game_over after the first of four pulses freezes the burst.
    match(3'd4);
    tick();
    check("halt first pulse", 32'(p_da), 32'h1);
    game_over   = 1'b1;
    guess_valid = 1'b1;
    guess_match = 1'b1;
    tick();
    guess_valid = 1'b0;
    guess_match = 1'b0;
    start       = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      start = 1'b0;
      if (p_da != '0) pulses++;
    end
    check("halt pulses", 32'(pulses), 32'd0);
    check("halt active", 32'(turn_active), 32'd0);
    check("halt busy", 32'(busy), 32'd0);
    check("halt cur", 32'(cur_player), 32'd0);
    do_reset();
    game_over = 1'b0;
    check("post-halt p_da", 32'(p_da), 32'd0);
    check("post-halt cur", 32'(cur_player), 32'd0);
    check("post-halt active", 32'(turn_active), 32'd0);
    check("post-halt busy", 32'(busy), 32'd0);

    // game_over arriving with a matched guess: no pulse at all.
    begin_game(4'd4);
    game_over = 1'b1;
    match(3'd1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (p_da != '0) pulses++;
    end
    check("go+guess pulses", 32'(pulses), 32'd0);
    check("go+guess active", 32'(turn_active), 32'd0);
    do_reset();
    game_over = 1'b0;

    // Turn timeout behaviour.
    begin_game(4'd2);
`ifdef TURN_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) tick();
    check("timeout k9 cur", 32'(cur_player), 32'd0);
    check("timeout k9 active", 32'(turn_active), 32'd1);
    tick();
    check("timeout k10 busy", 32'(busy), 32'd1);
    tick();
    check("timeout k11 cur", 32'(cur_player), 32'd1);
    check("timeout k11 active", 32'(turn_active), 32'd1);
`else
    for (int k = 0; k < 120; k++) tick();
    check("no-timeout cur", 32'(cur_player), 32'd0);
    check("no-timeout active", 32'(turn_active), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
